// File: rtl/fir_serial_pkg.sv
// Shared types and constants for the bit-serial FIR input path:
// the transmitter FSM state and the default serial word width.
package fir_serial_pkg;

  localparam int DEFAULT_DATA_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_word_tx_if.sv
// Parallel-word input and bit-serial output of the serial word transmitter.
// A transfer happens on a rising edge where valid && ready; valid never waits on ready.
interface serial_word_tx_if
  import fir_serial_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] i_word;
  logic                  i_word_valid;
  logic                  o_word_ready;
  logic                  i_en;
  logic                  i_ready;
  logic                  o_dout;
  logic                  o_dout_valid;
  logic                  o_busy;

  modport slave (
    input  i_word, i_word_valid, i_en, i_ready,
    output o_word_ready, o_dout, o_dout_valid, o_busy
  );

  modport master (
    output i_word, i_word_valid, i_en, i_ready,
    input  o_word_ready, o_dout, o_dout_valid, o_busy
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and a show-ahead head word.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module sync_fifo #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/serial_word_tx.sv
// Buffers parallel samples and sends each one LSB first as a bit-serial word,
// with a forced low gap on the valid line between consecutive words.
module serial_word_tx
  import fir_serial_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  serial_word_tx_if.slave   bus,
  output tx_state_t         o_state
);

  localparam int BW = cnt_width(DATA_WIDTH);
  localparam int GW = cnt_width(GAP_CYCLES);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  tx_state_t             state;
  tx_state_t             state_nxt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BW-1:0]         bit_cnt;
  logic [GW-1:0]         gap_cnt;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  push;
  logic                  pop;
  logic                  accept;
  logic                  last_bit;

  assign push     = bus.i_word_valid && !fifo_full;
  assign accept   = (state == SHIFT) && bus.i_en && bus.i_ready;
  assign last_bit = (bit_cnt == LAST_BIT);

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .din   (bus.i_word),
    .pop   (pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // A pop is only ever issued from IDLE or the end of GAP, so it never overlaps a shift.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_en && !fifo_empty) begin
          pop       = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (accept && last_bit) state_nxt = GAP;
      end
      GAP: begin
        if (bus.i_en && (gap_cnt == '0)) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = SHIFT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      if (pop) begin
        shift_reg <= fifo_head;
        bit_cnt   <= '0;
      end else if (accept && !last_bit) begin
        shift_reg <= shift_reg >> 1;
        bit_cnt   <= bit_cnt + 1'b1;
      end
      if (accept && last_bit) begin
        gap_cnt <= GAP_LOAD;
      end else if ((state == GAP) && bus.i_en && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  // The serial bit is the low bit of shift_reg while SHIFT, forced low otherwise.
  always_comb begin
    bus.o_dout_valid = (state == SHIFT);
    bus.o_dout       = (state == SHIFT) && shift_reg[0];
    bus.o_busy       = (state != IDLE) || !fifo_empty;
    bus.o_word_ready = !fifo_full;
    o_state          = state;
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Self-checking bench for serial_word_tx: a behavioural deserializer rebuilds words
// from accepted serial bits and the tasks compare them against the pushed samples.
module tb_serial_word_tx;
  import fir_serial_pkg::*;

  localparam int W   = 24;
  localparam int GAP = 1;

  logic      clk;
  logic      rst;
  tx_state_t state;

  serial_word_tx_if #(.DATA_WIDTH(W)) bus ();

  serial_word_tx #(
    .DATA_WIDTH (W),
    .FIFO_DEPTH (8),
    .GAP_CYCLES (GAP)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .bus     (bus),
    .o_state (state)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] rx_q[$];
  int           gap_q[$];
  bit           saw_full;
  bit           mon_clr;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural deserializer / monitor ----------------
  logic [W-1:0] acc;
  int           bit_n, low_run, mon_bits, mon_vhi, hold_breaks;
  bit           seen_word;
  logic         prev_valid, prev_dout, prev_acc;

  always @(posedge clk) begin
    if (rst || mon_clr) begin
      acc = '0; bit_n = 0; low_run = 0; mon_bits = 0; mon_vhi = 0; hold_breaks = 0;
      seen_word = 0; prev_valid = 0; prev_dout = 0; prev_acc = 0;
      rx_q.delete();
      gap_q.delete();
    end else begin
      if (prev_valid && !prev_acc && (bus.o_dout_valid !== prev_valid || bus.o_dout !== prev_dout))
        hold_breaks++;
      if (bus.i_en) begin
        if (bus.o_dout_valid) begin
          if (seen_word && low_run > 0) gap_q.push_back(low_run);
          low_run = 0;
          mon_vhi++;
          if (bus.i_ready) begin
            acc[bit_n] = bus.o_dout;
            bit_n++;
            mon_bits++;
            if (bit_n == W) begin
              rx_q.push_back(acc);
              bit_n = 0;
              seen_word = 1;
            end
          end
        end else if (seen_word) begin
          low_run++;
        end
      end
      prev_valid = bus.o_dout_valid;
      prev_dout  = bus.o_dout;
      prev_acc   = bus.i_en && bus.i_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_monitor();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_word(input logic [W-1:0] w);
    int budget = 500;
    bit ok = 0;
    bus.i_word       = w;
    bus.i_word_valid = 1'b1;
    while (!ok && budget > 0) begin
      ok = bus.o_word_ready;
      if (!ok) saw_full = 1'b1;
      tick();
      budget--;
    end
    bus.i_word_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_timeout: word %h not accepted, required acceptance within 500 cycles", w);
    end else begin
      exp_q.push_back(w);
    end
  endtask

  task automatic wait_idle();
    int budget = 3000;
    while (bus.o_busy && budget > 0) begin
      tick();
      budget--;
    end
    tick();
    checks++;
    if (bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: o_busy=%b, required 0 within 3000 cycles", bus.o_busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.i_en = 1'b1;
    bus.i_word = W'($urandom);
    bus.i_word_valid = 1'b1;
    tick();
    tick();
    checks++; if (bus.o_dout !== 1'b0) begin errors++; $display("FAIL rst_dout: got %b expected 0", bus.o_dout); end
    checks++; if (bus.o_dout_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.o_dout_valid); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.o_busy); end
    checks++; if (bus.o_word_ready !== 1'b1) begin errors++; $display("FAIL rst_word_ready: got %b expected 1", bus.o_word_ready); end
    checks++; if (state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d expected %0d", state, IDLE); end
    rst = 1'b0;
    bus.i_word_valid = 1'b0;
    tick();
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rst_no_push: busy got %b expected 0", bus.o_busy); end
  endtask

  task automatic test_single();
    logic [W-1:0] w = 24'hA5A5A5;
    bus.i_ready = 1'b1;
    bus.i_en = 1'b1;
    clear_monitor();
    push_word(w);
    checks++; if (bus.o_dout_valid !== 1'b0) begin errors++; $display("FAIL lat_early: valid got %b expected 0", bus.o_dout_valid); end
    tick();
    for (int k = 0; k < W; k++) begin
      checks++;
      if (bus.o_dout_valid !== 1'b1 || bus.o_dout !== w[k]) begin
        errors++;
        $display("FAIL single_bit%0d: valid/dout got %b/%b expected 1/%b", k, bus.o_dout_valid, bus.o_dout, w[k]);
      end
      tick();
    end
    checks++; if (bus.o_dout_valid !== 1'b0) begin errors++; $display("FAIL single_end: valid got %b expected 0", bus.o_dout_valid); end
    wait_idle();
    checks++; if (mon_vhi !== W) begin errors++; $display("FAIL single_vhi: got %0d expected %0d", mon_vhi, W); end
    checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL single_cnt: got %0d expected 1", rx_q.size()); end
    else begin
      checks++; if (rx_q[0] !== w) begin errors++; $display("FAIL single_word: got %h expected %h", rx_q[0], w); end
    end
  endtask

  task automatic test_ready_toggle();
    int budget = 500;
    bit phase = 1'b1;
    logic [W-1:0] w = 24'h800001;
    bus.i_ready = 1'b1;
    clear_monitor();
    push_word(w);
    while ((bus.o_busy || bus.o_dout_valid) && budget > 0) begin
      if (bus.o_dout_valid) begin
        bus.i_ready = phase;
        phase = !phase;
      end
      tick();
      budget--;
    end
    bus.i_ready = 1'b1;
    wait_idle();
    checks++; if (mon_bits !== W) begin errors++; $display("FAIL tog_bits: got %0d expected %0d", mon_bits, W); end
    checks++; if (mon_vhi !== 2 * W - 1) begin errors++; $display("FAIL tog_vhi: got %0d expected %0d", mon_vhi, 2 * W - 1); end
    checks++; if (hold_breaks !== 0) begin errors++; $display("FAIL tog_hold: got %0d breaks expected 0", hold_breaks); end
    checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL tog_cnt: got %0d expected 1", rx_q.size()); end
    else begin
      checks++; if (rx_q[0] !== w) begin errors++; $display("FAIL tog_word: got %h expected %h", rx_q[0], w); end
    end
  endtask

  task automatic test_burst();
    bus.i_ready = 1'b1;
    clear_monitor();
    saw_full = 1'b0;
    for (int i = 1; i <= 10; i++) push_word(W'(i));
    wait_idle();
    checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL burst_full: word_ready low seen=%b expected 1", saw_full); end
    checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL burst_cnt: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL burst_word%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if (gap_q.size() !== 9) begin errors++; $display("FAIL burst_gaps: got %0d gaps expected 9", gap_q.size()); end
    for (int i = 0; i < gap_q.size(); i++) begin
      checks++; if (gap_q[i] !== GAP) begin errors++; $display("FAIL burst_gap%0d: low for %0d cycles expected %0d", i, gap_q[i], GAP); end
    end
  endtask

  task automatic test_reset_mid();
    int budget = 500;
    logic [W-1:0] w = W'($urandom);
    bus.i_ready = 1'b1;
    clear_monitor();
    push_word(24'h7FFFFF);
    for (int i = 0; i < 3; i++) push_word(W'($urandom));
    while (mon_bits < 10 && budget > 0) begin
      tick();
      budget--;
    end
    checks++; if (mon_bits < 10) begin errors++; $display("FAIL mid_reach: bits got %0d expected >= 10", mon_bits); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.o_dout_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", bus.o_dout_valid); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", bus.o_busy); end
    checks++; if (bus.o_word_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", bus.o_word_ready); end
    exp_q.delete();
    push_word(w);
    wait_idle();
    checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL mid_cnt: got %0d expected 1", rx_q.size()); end
    else begin
      checks++; if (rx_q[0] !== w) begin errors++; $display("FAIL mid_word: got %h expected %h", rx_q[0], w); end
    end
  endtask

  task automatic test_enable();
    int budget = 500;
    logic fz_dout, fz_valid;
    bus.i_ready = 1'b1;
    bus.i_en = 1'b1;
    clear_monitor();
    push_word(W'($urandom));
    while (mon_bits < 7 && budget > 0) begin
      tick();
      budget--;
    end
    bus.i_en = 1'b0;
    fz_dout  = bus.o_dout;
    fz_valid = bus.o_dout_valid;
    push_word(W'($urandom));
    for (int i = 0; i < 19; i++) begin
      checks++;
      if (bus.o_dout !== fz_dout || bus.o_dout_valid !== fz_valid) begin
        errors++;
        $display("FAIL en_freeze%0d: dout/valid got %b/%b expected %b/%b", i, bus.o_dout, bus.o_dout_valid, fz_dout, fz_valid);
      end
      tick();
    end
    checks++; if (fz_valid !== 1'b1) begin errors++; $display("FAIL en_midword: valid got %b expected 1", fz_valid); end
    bus.i_en = 1'b1;
    wait_idle();
    checks++; if (hold_breaks !== 0) begin errors++; $display("FAIL en_hold: got %0d breaks expected 0", hold_breaks); end
    checks++; if (rx_q.size() !== 2) begin errors++; $display("FAIL en_cnt: got %0d expected 2", rx_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL en_word%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_loopback_random();
    logic [W-1:0] words[8];
    int idx = 0;
    int budget = 4000;
    bit ok;
    words[0] = 24'h000000;
    words[1] = 24'hFFFFFF;
    words[2] = 24'h800000;
    for (int i = 3; i < 8; i++) words[i] = W'($urandom);
    clear_monitor();
    while ((idx < 8 || bus.o_busy) && budget > 0) begin
      bus.i_ready = ($urandom_range(0, 3) != 0);
      bus.i_en    = ($urandom_range(0, 4) != 0);
      ok = 1'b0;
      if (idx < 8) begin
        bus.i_word       = words[idx];
        bus.i_word_valid = ($urandom_range(0, 1) != 0);
        ok = bus.i_word_valid && bus.o_word_ready;
      end
      tick();
      bus.i_word_valid = 1'b0;
      if (ok) begin
        exp_q.push_back(words[idx]);
        idx++;
      end
      budget--;
    end
    bus.i_en = 1'b1;
    bus.i_ready = 1'b1;
    wait_idle();
    checks++; if (hold_breaks !== 0) begin errors++; $display("FAIL lb_hold: got %0d breaks expected 0", hold_breaks); end
    checks++; if (rx_q.size() !== 8) begin errors++; $display("FAIL lb_cnt: got %0d expected 8", rx_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL lb_word%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    mon_clr = 1'b0;
    saw_full = 1'b0;
    bus.i_word = '0;
    bus.i_word_valid = 1'b0;
    bus.i_en = 1'b1;
    bus.i_ready = 1'b1;
    tick();
    test_reset();
    test_single();
    test_ready_toggle();
    test_burst();
    test_reset_mid();
    test_enable();
    test_loopback_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
